// File: rtl/mcm_tap_accumulator.sv
// Purpose : sums NUM_TAPS signed MCM products into one rounded, shifted, clipped 8-bit sample.
// Latency : the sample is registered and visible the cycle after its final tap is accepted.
// Backpr. : only the final tap stalls, and only when the output register is full and not draining.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clr                 synchronous clear of the partial sum, tap and row counters
//   in_valid/in_ready   product handshake; in_ready is combinational
//   in_prod             signed 16-bit product for the current tap
//   out_valid/out_ready sample handshake (single-entry output register)
//   out_sample          unsigned clipped sample
//   out_last            sample is the last one of its prediction row
module mcm_tap_accumulator #(
  parameter int NUM_TAPS   = 4,
  parameter int SHIFT      = 6,
  parameter int ACC_W      = 20,
  parameter int BLOCK_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_sample,
  output logic        out_last
);

  localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int SW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  localparam logic [TW-1:0]    LAST_TAP  = TW'(NUM_TAPS - 1);
  localparam logic [SW-1:0]    LAST_SAMP = SW'(BLOCK_SIZE - 1);
  localparam logic [ACC_W-1:0] RND       = ACC_W'(1) << (SHIFT - 1);

  logic [ACC_W-1:0] r_acc;
  logic [TW-1:0]    r_tap_cnt;
  logic [SW-1:0]    r_samp_cnt;
  logic             r_out_valid;
  logic [7:0]       r_out_sample;
  logic             r_out_last;

  logic                    w_final;
  logic                    w_in_ready;
  logic                    w_accept;
  logic [ACC_W-1:0]        w_prod_ext;
  logic [ACC_W-1:0]        w_acc_nxt;
  logic [ACC_W-1:0]        w_sum;
  logic signed [ACC_W-1:0] w_res;
  logic [7:0]              w_clip;
  logic                    w_row_end;

  // ACCUM while tap_cnt < NUM_TAPS-1, FINAL on the last tap of a group.
  assign w_final = (r_tap_cnt == LAST_TAP);

  // The final tap needs a free (or draining) output slot; earlier taps never stall.
  assign w_in_ready = !clr && (!w_final || !r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Accumulator arithmetic wraps modulo 2^ACC_W by construction.
  assign w_prod_ext = {{(ACC_W-16){in_prod[15]}}, in_prod};
  assign w_acc_nxt  = r_acc + w_prod_ext;
  assign w_sum      = w_acc_nxt + RND;
  assign w_res      = $signed(w_sum) >>> SHIFT;
  assign w_row_end  = (r_samp_cnt == LAST_SAMP);

  // Clip to [0,255]: negative -> 0, any bit above bit 7 set -> 255.
  always_comb begin
    w_clip = w_res[7:0];
    if (w_res[ACC_W-1]) begin
      w_clip = 8'd0;
    end else if (|w_res[ACC_W-2:8]) begin
      w_clip = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_tap_cnt    <= '0;
      r_samp_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= 8'd0;
      r_out_last   <= 1'b0;
    end else begin
      // Drain first; a load in the same cycle below overrides the clear.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      // clr never touches the output register, so a pending sample still completes.
      if (clr) begin
        r_acc      <= '0;
        r_tap_cnt  <= '0;
        r_samp_cnt <= '0;
      end else if (w_accept) begin
        if (w_final) begin
          r_out_valid  <= 1'b1;
          r_out_sample <= w_clip;
          r_out_last   <= w_row_end;
          r_acc        <= '0;
          r_tap_cnt    <= '0;
          r_samp_cnt   <= w_row_end ? '0 : r_samp_cnt + 1'b1;
        end else begin
          r_acc     <= w_acc_nxt;
          r_tap_cnt <= r_tap_cnt + 1'b1;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign out_last   = r_out_last;

endmodule
